// File: rtl/wb_reg_resp.sv
// Wishbone classic responder serving ID, CTRL, SCRATCH and a free-running CNT register,
// acknowledging each access after WAIT_CYCLES wait states.
module wb_reg_resp #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5746_4701,
    parameter logic [31:0] CTRL_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_wbs_adr,
    input  logic [31:0] io_wbs_datwr,
    output logic [31:0] io_wbs_datrd,
    input  logic        io_wbs_we,
    input  logic        io_wbs_stb,
    input  logic        io_wbs_cyc,
    output logic        io_wbs_ack,
    output logic [31:0] ctrl_o,
    output logic        cnt_wrap_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [1:0] OFF_ID      = 2'd0;
    localparam logic [1:0] OFF_CTRL    = 2'd1;
    localparam logic [1:0] OFF_SCRATCH = 2'd2;
    localparam logic [3:0] WAIT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_sel;
    logic        r_we;
    logic [31:0] r_dat;
    logic [3:0]  r_wait;
    logic        r_ack;
    logic [31:0] r_datrd;
    logic [31:0] r_ctrl;
    logic [31:0] r_scratch;
    logic [31:0] r_cnt;
    logic        r_wrap;

    logic        w_req;
    logic        w_inc;
    logic        w_wr_en;
    logic [31:0] w_cnt_next;
    logic [1:0]  w_rd_sel;
    logic [31:0] w_rd_data;
    logic        w_unused;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_req      = io_wbs_cyc & io_wbs_stb;
        w_inc      = r_ctrl[0];
        w_wr_en    = (r_state == S_ACK) && r_we;
        w_cnt_next = w_inc ? r_cnt + 32'd1 : r_cnt;
        w_rd_sel   = (r_state == S_IDLE) ? io_wbs_adr[3:2] : r_sel;
        w_rd_data  = ID_VALUE;
        case (w_rd_sel)
            OFF_ID:      w_rd_data = ID_VALUE;
            OFF_CTRL:    w_rd_data = r_ctrl;
            OFF_SCRATCH: w_rd_data = r_scratch;
            default:     w_rd_data = w_cnt_next;
        endcase
    end

    // Upper address bits are matched by the upstream mux; byte lanes are not decoded.
    assign w_unused = ^{io_wbs_adr[31:4], io_wbs_adr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= CTRL_RESET;
            r_scratch <= 32'd0;
            r_cnt     <= 32'd0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            // A CNT write wins over the increment and never reports a wrap.
            if (w_wr_en && (r_sel == 2'd3)) begin
                r_cnt <= r_dat;
            end else if (w_inc) begin
                r_cnt  <= r_cnt + 32'd1;
                r_wrap <= (r_cnt == 32'hFFFF_FFFF);
            end
            if (w_wr_en && (r_sel == OFF_CTRL)) begin
                r_ctrl <= r_dat;
            end
            if (w_wr_en && (r_sel == OFF_SCRATCH)) begin
                r_scratch <= r_dat;
            end
        end
    end

    // Read data is registered on entry to ACK; w_cnt_next is the CNT value the ACK cycle will hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_we    <= 1'b0;
            r_dat   <= 32'd0;
            r_wait  <= 4'd0;
            r_ack   <= 1'b0;
            r_datrd <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_sel <= io_wbs_adr[3:2];
                        r_we  <= io_wbs_we;
                        r_dat <= io_wbs_datwr;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            r_datrd <= w_rd_data;
                        end else begin
                            r_wait  <= WAIT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_wait == 4'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_datrd <= w_rd_data;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_datrd <= 32'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_datrd <= 32'd0;
                end
            endcase
        end
    end

    assign io_wbs_ack   = r_ack;
    assign io_wbs_datrd = r_datrd;
    assign ctrl_o       = r_ctrl;
    assign cnt_wrap_o   = r_wrap;

endmodule

// File: doc/wb_reg_resp.md
# wb_reg_resp

Wishbone classic responder (peripheral end) sitting behind one output port of the Wishbone address multiplexer. It decodes the word offset of each access and serves four 32-bit registers: ID, control, scratch and a free-running cycle counter. It acknowledges each access after a programmable number of wait states. The control word and a counter-wrap pulse are exported to the waveform-generator logic.

## Interface
- `WAIT_CYCLES`, default 1: wait states inserted before `ack`; legal range 0..15.
- `ID_VALUE`, default 32'h5746_4701: constant returned by the ID register.
- `CTRL_RESET`, default 32'h0000_0000: reset value of the CTRL register.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `io_wbs_adr`  in  32: byte address. Only bits [3:2] are decoded; upstream mux has already matched the upper bits.
- `io_wbs_datwr`  in  32: write data.
- `io_wbs_datrd`  out  32: read data. Valid only while `io_wbs_ack`=1; otherwise 0.
- `io_wbs_we`  in  1: 1 = write, 0 = read.
- `io_wbs_stb`  in  1: strobe.
- `io_wbs_cyc`  in  1: cycle valid.
- `io_wbs_ack`  out  1: single-cycle acknowledge.
- `ctrl_o`  out  32: current CTRL register value.
- `cnt_wrap_o`  out  1: one-cycle pulse when CNT wraps 32'hFFFF_FFFF -> 0.

## Operation
- Register map (`adr[3:2]`):
  - 0 ID: read-only; returns `ID_VALUE`; writes are acknowledged and ignored.
  - 1 CTRL: read/write; drives `ctrl_o`.
  - 2 SCRATCH: read/write; no side effect.
  - 3 CNT: read/write. Increments by 1 every cycle while `CTRL[0]`=1; holds otherwise. A write loads `datwr`.
- FSM states and transitions:
  - IDLE: on `cyc & stb`, latch `adr[3:2]`, `we` and `datwr`. Go to ACK if `WAIT_CYCLES`=0; otherwise load the wait counter with `WAIT_CYCLES`-1 and go to WAIT.
  - WAIT: if `cyc`=0 or `stb`=0, abort to IDLE with no ack and no write. If the counter is 0, go to ACK; else decrement.
  - ACK: `ack`=1 for exactly this cycle. The register write (if `we`) takes effect at the end of this cycle, and `datrd` shows the selected register. Always go to IDLE.
- `ack` is never high in two consecutive cycles. The master's deassertion cycle is always spent in IDLE.
- A request still asserted in the IDLE cycle after ACK is treated as a new access. The master is expected to drop `stb` on `ack`.
- CNT read data is the value held at the start of the ACK cycle, before that cycle's increment.
- Write to CNT coincident with an increment: the write wins, and the counter holds the written value for that edge.
- Wrap: the CNT increment from 32'hFFFF_FFFF produces 0, and `cnt_wrap_o`=1 in the following cycle. A write of any value never pulses `cnt_wrap_o`.
- CTRL written with bit0=0 freezes CNT from the next edge.
- `rst_n` low at any time, including mid-WAIT/ACK: FSM -> IDLE immediately. A pending write is discarded.
- Reset values: `io_wbs_ack`=0, `io_wbs_datrd`=0, `cnt_wrap_o`=0, CTRL=`CTRL_RESET` (so `ctrl_o`=`CTRL_RESET`), SCRATCH=0, CNT=0.

## Timing
- The request is sampled at rising edge N (`cyc & stb` high). `ack` and `datrd` are registered and high during cycle N+1+`WAIT_CYCLES`. The master samples them at edge N+2+`WAIT_CYCLES`.
- With `WAIT_CYCLES`=0: a 2-cycle access, plus 1 idle cycle, gives a minimum spacing of 3 cycles between back-to-back accesses. General spacing is 3+`WAIT_CYCLES`.
- `ctrl_o` updates on the edge that ends the ACK cycle. `cnt_wrap_o` is registered with 1-cycle latency after the wrap edge.
- `datrd` is driven 0 in every non-ACK cycle. There is no combinational path from inputs to any output.

## Test plan
- Reset, then read offset 0 with `WAIT_CYCLES`=1 -> `ack` in cycle N+2, `datrd`=32'h5746_4701. All outputs are 0 / `CTRL_RESET` before the access.
- Write 32'hA5A5_5A5A to SCRATCH, then read back -> a single-cycle `ack` for each access, read returns 32'hA5A5_5A5A. ID write of 32'h0 leaves ID at 32'h5746_4701.
- Write CNT=32'hFFFF_FFFD, then CTRL=1, then wait -> CNT reaches 0 after 3 increments, `cnt_wrap_o` pulses exactly one cycle, CNT continues 1, 2, …. Write CTRL=0 -> CNT frozen.
- Drop `stb` during WAIT with `WAIT_CYCLES`=4 and a write to SCRATCH -> no `ack`, SCRATCH unchanged. The next full access completes normally.
- Assert `rst_n`=0 during the ACK cycle of a CTRL write of 32'hFFFF_FFFF -> `ack` drops immediately, `ctrl_o`=`CTRL_RESET`.
- Run 1000 random back-to-back read/write accesses with `WAIT_CYCLES` ∈ {0, 3, 15} -> a reference-model match on every `datrd`, and `ack` never high in two consecutive cycles.
